// File: rtl/dnn_pkg.sv
// Shared constants and types for the DNN datapath stages.
// Holds the result width, saturation limits and the accumulator state encoding.
package dnn_pkg;

   localparam int DATA_W = 16;
   localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
   localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;

   typedef enum logic {IDLE, ACCUM} acc_state_t;

endpackage

// File: rtl/sat_shift.sv
// Arithmetic right shift of a wide signed value, then clamp to 16-bit signed.
// Purely combinational; ovf flags any clipping. No handshake.
module sat_shift
   import dnn_pkg::*;
#(
   parameter int ACC_W = 40,
   parameter int SHIFT = 8
) (
   input  logic signed [ACC_W-1:0]  din,
   output logic        [DATA_W-1:0] dout,
   output logic                     ovf
);

   logic signed [ACC_W-1:0] shifted;
   logic signed [ACC_W-1:0] max_ext;
   logic signed [ACC_W-1:0] min_ext;

   assign shifted = din >>> SHIFT;
   assign max_ext = {{(ACC_W-DATA_W){1'b0}}, SAT_MAX};
   assign min_ext = {{(ACC_W-DATA_W){1'b1}}, SAT_MIN};

   always_comb begin
      dout = shifted[DATA_W-1:0];
      ovf  = 1'b0;
      if (shifted > max_ext) begin
         dout = SAT_MAX;
         ovf  = 1'b1;
      end else if (shifted < min_ext) begin
         dout = SAT_MIN;
         ovf  = 1'b1;
      end
   end

endmodule

// File: rtl/acc_bp.sv
// Dot-product accumulator: sums vec_len signed products, emits sat16(sum >>> SHIFT) 1 cycle after the last accept.
// Stalls upstream only while a result is held under backpressure; ACC_BP_RELU_EN clamps negative results to 0.
module acc_bp
   import dnn_pkg::*;
#(
   parameter int LEN_W = 8,
   parameter int SHIFT = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [LEN_W-1:0]  vec_len,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              backpressure_out,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              backpressure_in,
   output logic              out_last_ovf
);

   localparam int ACC_W = 32 + LEN_W;

   acc_state_t              state;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_next;
   logic signed [ACC_W-1:0] in_ext;
   logic [LEN_W-1:0]        count;
   logic [LEN_W-1:0]        cnt_next;
   logic [LEN_W-1:0]        len_r;
   logic [LEN_W-1:0]        len_eff;
   logic                    accept;
   logic                    pop;
   logic                    last;
   logic [DATA_W-1:0]       sat_dat;
   logic                    sat_ovf;
   logic [DATA_W-1:0]       res_dat;
   logic                    res_ovf;

   assign backpressure_out = out_valid && backpressure_in;
   assign accept           = in_valid && !backpressure_out;
   assign pop              = out_valid && !backpressure_in;
   assign in_ext           = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};

   // The first element of a vector restarts the sum and samples the length.
   always_comb begin
      acc_next = acc + in_ext;
      cnt_next = count + LEN_W'(1);
      len_eff  = len_r;
      if (state == IDLE) begin
         acc_next = in_ext;
         cnt_next = LEN_W'(1);
         len_eff  = (vec_len == '0) ? LEN_W'(1) : vec_len;
      end
      last = accept && (cnt_next == len_eff);
   end

   sat_shift #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT)
   ) u_sat (
      .din  (acc_next),
      .dout (sat_dat),
      .ovf  (sat_ovf)
   );

`ifdef ACC_BP_RELU_EN
   // An arithmetic shift keeps the sign, so the sum's MSB marks a negative result.
   always_comb begin
      res_dat = sat_dat;
      res_ovf = sat_ovf;
      if (acc_next[ACC_W-1]) begin
         res_dat = '0;
         res_ovf = 1'b0;
      end
   end
`else
   assign res_dat = sat_dat;
   assign res_ovf = sat_ovf;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= IDLE;
         acc          <= '0;
         count        <= '0;
         len_r        <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_last_ovf <= 1'b0;
      end else begin
         if (accept) begin
            acc <= acc_next;
            if (state == IDLE) begin
               len_r <= len_eff;
            end
            if (last) begin
               state <= IDLE;
               count <= '0;
            end else begin
               state <= ACCUM;
               count <= cnt_next;
            end
         end
         if (last) begin
            out_valid    <= 1'b1;
            out_data     <= res_dat;
            out_last_ovf <= res_ovf;
         end else if (pop) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_acc_bp.sv
// Bench for acc_bp: two instances (SHIFT=0 and SHIFT=8) share stimulus and are checked
// against a queue-based vector-sum model every cycle, plus directed vectors with fixed expectations.
module tb_acc_bp;

   logic        clk;
   logic        resetn;
   logic [7:0]  vec_len;
   logic        in_valid;
   logic [15:0] in_data;
   logic        backpressure_in;
   logic        bpo0, bpo8, v0, v8, o0, o8;
   logic [15:0] d0, d8;

   int checks;
   int failures;

   acc_bp #(.LEN_W(8), .SHIFT(0)) u_dut0 (
      .clk(clk), .resetn(resetn), .vec_len(vec_len), .in_valid(in_valid), .in_data(in_data),
      .backpressure_out(bpo0), .out_valid(v0), .out_data(d0),
      .backpressure_in(backpressure_in), .out_last_ovf(o0));

   acc_bp #(.LEN_W(8), .SHIFT(8)) u_dut8 (
      .clk(clk), .resetn(resetn), .vec_len(vec_len), .in_valid(in_valid), .in_data(in_data),
      .backpressure_out(bpo8), .out_valid(v8), .out_data(d8),
      .backpressure_in(backpressure_in), .out_last_ovf(o8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: products collected per vector, summed with plain integer arithmetic.
   logic        m_valid;
   logic [15:0] m_d0, m_d8;
   logic        m_o0, m_o8;
   logic        m_in_vec;
   int          m_tgt;
   int          m_vec[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void calc(input longint s, input int sh, output logic [15:0] r, output logic o);
      longint t;
      t = s >>> sh;
      o = 1'b0;
`ifdef ACC_BP_RELU_EN
      if (t < 0) t = 0;
`endif
      if (t > 32767) begin
         t = 32767;
         o = 1'b1;
      end else if (t < -32768) begin
         t = -32768;
         o = 1'b1;
      end
      r = t[15:0];
   endfunction

   function automatic void model_reset();
      m_valid  = 1'b0;
      m_d0     = '0;
      m_d8     = '0;
      m_o0     = 1'b0;
      m_o8     = 1'b0;
      m_in_vec = 1'b0;
      m_tgt    = 0;
      m_vec.delete();
   endfunction

   function automatic void model_step(input logic v, input logic [15:0] d, input logic [7:0] l,
                                      input logic bpi, input logic rn);
      logic   acc, pop, load;
      longint s;
      if (!rn) begin
         model_reset();
         return;
      end
      acc  = v && !(m_valid && bpi);
      pop  = m_valid && !bpi;
      load = 1'b0;
      if (acc) begin
         if (!m_in_vec) begin
            m_tgt = (l == 0) ? 1 : int'(l);
            m_vec.delete();
            m_in_vec = 1'b1;
         end
         m_vec.push_back(int'($signed(d)));
         if (m_vec.size() == m_tgt) begin
            s = 0;
            foreach (m_vec[i]) s += m_vec[i];
            calc(s, 0, m_d0, m_o0);
            calc(s, 8, m_d8, m_o8);
            load = 1'b1;
            m_in_vec = 1'b0;
         end
      end
      if (load) m_valid = 1'b1;
      else if (pop) m_valid = 1'b0;
   endfunction

   // One clock: drive inputs, compare outputs before the edge, then advance the model.
   task automatic cycle(input logic v, input logic [15:0] d, input logic [7:0] l,
                        input logic bpi, input logic rn);
      in_valid = v; in_data = d; vec_len = l; backpressure_in = bpi; resetn = rn;
      #1;
      chk("bp_out0", bpo0, m_valid && bpi);
      chk("bp_out8", bpo8, m_valid && bpi);
      chk("valid0", v0, m_valid);
      chk("valid8", v8, m_valid);
      if (m_valid) begin
         chk("data0", d0, m_d0);
         chk("ovf0", o0, m_o0);
         chk("data8", d8, m_d8);
         chk("ovf8", o8, m_o8);
      end
      @(posedge clk);
      model_step(v, d, l, bpi, rn);
      #1;
   endtask

   task automatic exp_out(input string nm, input logic [15:0] e0, input logic eo0,
                          input logic [15:0] e8, input logic eo8);
      chk({nm, "_valid"}, v0, 1'b1);
      chk({nm, "_d0"}, d0, e0);
      chk({nm, "_o0"}, o0, eo0);
      chk({nm, "_d8"}, d8, e8);
      chk({nm, "_o8"}, o8, eo8);
   endtask

   typedef struct {
      logic [7:0]       len;
      int               n;
      logic [3:0][15:0] p;
      logic             gap;
      logic [15:0]      e0;
      logic             eo0;
      logic [15:0]      e8;
      logic             eo8;
   } tv_t;

   function automatic tv_t mk(input logic [7:0] len, input int n, input logic [15:0] a,
                              input logic [15:0] b, input logic [15:0] c, input logic [15:0] dd,
                              input logic gap, input logic [15:0] e0, input logic eo0,
                              input logic [15:0] e8, input logic eo8);
      tv_t t;
      t.len = len; t.n = n; t.gap = gap;
      t.p[0] = a; t.p[1] = b; t.p[2] = c; t.p[3] = dd;
      t.e0 = e0; t.eo0 = eo0; t.e8 = e8; t.eo8 = eo8;
      return t;
   endfunction

   tv_t tbl[7];

   initial begin
      checks = 0;
      failures = 0;
      tbl[0] = mk(8'd4, 4, 16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 16'd10, 1'b0, 16'd0, 1'b0);
      tbl[1] = mk(8'd3, 3, 16'h0100, 16'hFF00, 16'h0300, 16'd0, 1'b1, 16'd768, 1'b0, 16'd3, 1'b0);
      tbl[2] = mk(8'd2, 2, 16'h7FFF, 16'h7FFF, 16'd0, 16'd0, 1'b0, 16'h7FFF, 1'b1, 16'd255, 1'b0);
`ifdef ACC_BP_RELU_EN
      tbl[3] = mk(8'd2, 2, 16'h8000, 16'h8000, 16'd0, 16'd0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
      tbl[6] = mk(8'd3, 3, 16'hFFFB, 16'd2, 16'd1, 16'd0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
`else
      tbl[3] = mk(8'd2, 2, 16'h8000, 16'h8000, 16'd0, 16'd0, 1'b0, 16'h8000, 1'b1, 16'hFF00, 1'b0);
      tbl[6] = mk(8'd3, 3, 16'hFFFB, 16'd2, 16'd1, 16'd0, 1'b1, 16'hFFFE, 1'b0, 16'hFFFF, 1'b0);
`endif
      tbl[4] = mk(8'd1, 1, 16'd5, 16'd0, 16'd0, 16'd0, 1'b0, 16'd5, 1'b0, 16'd0, 1'b0);
      tbl[5] = mk(8'd0, 1, 16'd7, 16'd0, 16'd0, 16'd0, 1'b0, 16'd7, 1'b0, 16'd0, 1'b0);

      // Reset state.
      resetn = 1'b0; in_valid = 1'b0; in_data = '0; vec_len = '0; backpressure_in = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();
      #1;
      chk("rst_valid0", v0, 1'b0);
      chk("rst_data0", d0, 16'd0);
      chk("rst_ovf0", o0, 1'b0);
      chk("rst_bp0", bpo0, 1'b0);
      chk("rst_valid8", v8, 1'b0);
      chk("rst_data8", d8, 16'd0);
      cycle(1'b0, 16'd0, 8'd0, 1'b0, 1'b1);

      // Directed vectors; gap cycles carry a bogus vec_len that must be ignored.
      for (int i = 0; i < 7; i++) begin
         for (int k = 0; k < tbl[i].n; k++) begin
            cycle(1'b1, tbl[i].p[k], tbl[i].len, 1'b0, 1'b1);
            if (tbl[i].gap && k < tbl[i].n - 1) cycle(1'b0, 16'hDEAD, 8'd77, 1'b0, 1'b1);
            if (k < tbl[i].n - 1) chk($sformatf("vec%0d_early", i), v0, 1'b0);
         end
         exp_out($sformatf("vec%0d", i), tbl[i].e0, tbl[i].eo0, tbl[i].e8, tbl[i].eo8);
         cycle(1'b0, 16'd0, 8'd0, 1'b0, 1'b1);
      end

      // Held result under backpressure while upstream keeps offering data.
      cycle(1'b1, 16'd10, 8'd2, 1'b0, 1'b1);
      cycle(1'b1, 16'd20, 8'd2, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, 16'd100, 8'd1, 1'b1, 1'b1);
         chk("hold_bp", bpo0, 1'b1);
         chk("hold_valid", v0, 1'b1);
         chk("hold_data", d0, 16'd30);
      end
      cycle(1'b1, 16'd100, 8'd1, 1'b0, 1'b1);
      exp_out("release", 16'd100, 1'b0, 16'd0, 1'b0);
      cycle(1'b0, 16'd0, 8'd0, 1'b0, 1'b1);
      chk("release_drain", v0, 1'b0);

      // Single-element vectors back to back, vec_len 0 treated as 1.
      cycle(1'b1, 16'd5, 8'd1, 1'b0, 1'b1);
      chk("len1_a", d0, 16'd5);
      cycle(1'b1, 16'd6, 8'd0, 1'b0, 1'b1);
      chk("len1_b", d0, 16'd6);
      chk("len1_b_valid", v0, 1'b1);
      cycle(1'b1, 16'd7, 8'd1, 1'b0, 1'b1);
      chk("len1_c", d0, 16'd7);
      cycle(1'b0, 16'd0, 8'd0, 1'b0, 1'b1);

      // Reset in the middle of a vector, then a fresh vector.
      cycle(1'b1, 16'd1, 8'd4, 1'b0, 1'b1);
      cycle(1'b1, 16'd1, 8'd4, 1'b0, 1'b1);
      cycle(1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
      chk("midrst_valid", v0, 1'b0);
      cycle(1'b1, 16'd9, 8'd2, 1'b0, 1'b1);
      chk("midrst_early", v0, 1'b0);
      cycle(1'b1, 16'd1, 8'd2, 1'b0, 1'b1);
      exp_out("midrst", 16'd10, 1'b0, 16'd0, 1'b0);
      cycle(1'b0, 16'd0, 8'd0, 1'b0, 1'b1);

      // Randomised traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         logic        rv, rb, rr;
         logic [15:0] rd;
         logic [7:0]  rl;
         rv = ($urandom_range(0, 3) != 0);
         rb = ($urandom_range(0, 3) == 0);
         rr = ($urandom_range(0, 499) != 0);
         rl = 8'($urandom_range(0, 6));
         if ($urandom_range(0, 3) == 0) rd = 16'($urandom);
         else rd = 16'($urandom_range(0, 600)) - 16'd300;
         cycle(rv, rd, rl, rb, rr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
